text_display_controller: RTL

Sequences the 16-glyph character generator to produce a 640x480 text-mode raster: 80 columns x 30 rows of 8x16-dot cells.
- Generates h/v raster timing and reads character codes from a 1-cycle-latency synchronous text RAM.
- Drives the generator's character/dot_count/scan_count/en inputs and re-aligns sync/blank with the generator's registered pixel.
- Sits between the LC3 video text buffer and the display pins.

---
 rtl/text_video_pkg.sv | 32 +++
 rtl/video_timing_counter.sv | 80 ++++++++
 rtl/text_display_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/text_video_pkg.sv
// Shared definitions for the 80x30 text-mode raster controller.
// Holds the default 640x480 timing, cell geometry, text-RAM address width,
// the character code type and the row-to-address helper.
package text_video_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CNT_W  = 10;

    typedef logic [3:0] char_code_t;

    // row * 80 as (row << 6) + (row << 4); avoids a multiplier.
    function automatic logic [ADDR_W-1:0] row_base(input logic [5:0] row);
        return {row, 6'b000000} + {2'b00, row, 4'b0000};
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters and stage-0 region decode.
// Ports:
//   clk, rst_n         pixel clock, async active-low reset
//   display_en         text enable, folded into active0
//   h_cnt, v_cnt       current dot / line position
//   hs0, vs0           raw sync regions (active high, undelayed)
//   active0            visible area and display enabled
//   frame_start        single-cycle pulse at h_cnt=0, v_cnt=0
//   vblank             line counter is past the visible area
module video_timing_counter
    import text_video_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             display_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hs0,
    output logic             vs0,
    output logic             active0,
    output logic             frame_start,
    output logic             vblank
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS_L  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_L  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign hs0    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs0    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    assign vblank = (v_cnt_q >= V_VIS_L);

    // The counters rest at 0/0 during reset; gating with rst_n keeps the
    // read strobe and the frame pulse quiet until reset is released.
    assign active0     = rst_n & display_en & (h_cnt_q < H_VIS_L) & (v_cnt_q < V_VIS_L);
    assign frame_start = rst_n & (h_cnt_q == '0) & (v_cnt_q == '0);

endmodule

// File: rtl/text_display_controller.sv
// Text-mode raster controller: 80x30 cells of 8x16 dots on a 640x480 raster.
// Stage 0 computes the text-RAM address from the counters, stage 1 presents
// the cell code and dot/scan position to the character generator, stage 2
// lines sync and blank up with the generator's registered pixel.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   display_en                 0 blanks video while timing keeps running
//   txt_addr, txt_rd_en        text RAM read port (row*80 + col)
//   txt_data                   character code, one cycle after the read
//   cg_character, cg_dot_count, cg_scan_count, cg_en   generator inputs
//   cg_pixel                   generator output dot
//   video_out, hsync_n, vsync_n, blank   display pins
//   frame_start, vblank        stage-0 frame markers for the CPU side
module text_display_controller
    import text_video_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        display_en,
    output logic [11:0] txt_addr,
    output logic        txt_rd_en,
    input  logic [3:0]  txt_data,
    output logic [3:0]  cg_character,
    output logic [2:0]  cg_dot_count,
    output logic [3:0]  cg_scan_count,
    output logic        cg_en,
    input  logic        cg_pixel,
    output logic        video_out,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank,
    output logic        frame_start,
    output logic        vblank
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             hs0, vs0, active0;

    video_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .display_en  (display_en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hs0         (hs0),
        .vs0         (vs0),
        .active0     (active0),
        .frame_start (frame_start),
        .vblank      (vblank)
    );

    // Stage 0: text RAM address.
    logic [5:0]        row;
    logic [6:0]        col;
    logic [ADDR_W-1:0] addr0;

    assign row   = v_cnt[9:4];
    assign col   = h_cnt[9:3];
    assign addr0 = row_base(row) + {5'b00000, col};

    assign txt_rd_en = active0;
    assign txt_addr  = active0 ? addr0 : '0;

    // Stage 1 (generator inputs) and stage 2 (pin alignment).
    logic [2:0] dot_q, dot_d;
    logic [3:0] scan_q, scan_d;
    logic       cg_en_q, cg_en_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    logic       blank1_q, blank1_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       blank_q, blank_d;

    always_comb begin
        dot_d     = h_cnt[2:0];
        scan_d    = v_cnt[3:0];
        cg_en_d   = active0;
        hs1_d     = hs0;
        vs1_d     = vs0;
        blank1_d  = ~active0;
        hsync_n_d = ~hs1_q;
        vsync_n_d = ~vs1_q;
        blank_d   = blank1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dot_q     <= '0;
            scan_q    <= '0;
            cg_en_q   <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            blank1_q  <= 1'b1;
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            blank_q   <= 1'b1;
        end else begin
            dot_q     <= dot_d;
            scan_q    <= scan_d;
            cg_en_q   <= cg_en_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            blank1_q  <= blank1_d;
            hsync_n_q <= hsync_n_d;
            vsync_n_q <= vsync_n_d;
            blank_q   <= blank_d;
        end
    end

    // RAM latency is one cycle, so the read data already lines up with stage 1.
    assign cg_character  = char_code_t'(txt_data);
    assign cg_dot_count  = dot_q;
    assign cg_scan_count = scan_q;
    assign cg_en         = cg_en_q;

    // The generator holds its last pixel while cg_en=0; blank masks it.
    assign hsync_n   = hsync_n_q;
    assign vsync_n   = vsync_n_q;
    assign blank     = blank_q;
    assign video_out = cg_pixel & ~blank_q;

endmodule
